// File: rtl/clk_div_ctrl.sv
// Run/stop and reconfiguration controller for the toggle-counter clock divider.
// New half-period values are applied only at the end of a full period, so clk_out never glitches.
module clk_div_ctrl #(
  parameter int          CNT_W        = 18,
  parameter int unsigned DEFAULT_HALF = 32'd249999
) (
  input  logic             clk_MHz,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] cur_half_r, cur_half_s;
  logic [CNT_W-1:0] pend_r, pend_s;
  logic             pend_valid_r, pend_valid_s;
  logic             clk_out_r, clk_out_s;
  logic             tick_r, tick_s;
  logic             cfg_ready_r, cfg_ready_s;
  logic             cfg_err_r, cfg_err_s;

  logic             counting_s;
  logic             term_s;
  logic             bnd_s;
  logic             xfer_s;
  logic             bad_s;
  logic             ok_s;

  assign counting_s = (state_r != S_IDLE);
  assign term_s     = counting_s && (cnt_r == cur_half_r);
  // Full-period boundary: the terminal count reached while clk_out is high.
  assign bnd_s      = term_s && clk_out_r;
  assign xfer_s     = cfg_valid && cfg_ready_r;
  assign bad_s      = xfer_s && (cfg_half == {CNT_W{1'b0}});
  assign ok_s       = xfer_s && !bad_s;

  // State register.
  always_ff @(posedge clk_MHz) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: STOP only falls back to IDLE on a period boundary.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  state_s = run ? S_RUN : S_IDLE;
      S_RUN:   state_s = run ? S_RUN : S_STOP;
      S_STOP: begin
        if (run) begin
          state_s = S_RUN;
        end else if (bnd_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_STOP;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Output/datapath next values: counter, divided clock, handshake and config registers.
  always_comb begin
    cnt_s        = cnt_r;
    clk_out_s    = clk_out_r;
    tick_s       = 1'b0;
    cur_half_s   = cur_half_r;
    pend_s       = pend_r;
    pend_valid_s = pend_valid_r;
    cfg_err_s    = bad_s;
    // Ready stays low for one extra cycle after a pending value is applied.
    cfg_ready_s  = (ok_s && counting_s) ? 1'b0 : !pend_valid_r;
    if (!counting_s) begin
      cnt_s     = {CNT_W{1'b0}};
      clk_out_s = 1'b0;
      if (ok_s) begin
        cur_half_s = cfg_half;
      end else begin
        cur_half_s = cur_half_r;
      end
    end else begin
      if (term_s) begin
        cnt_s     = {CNT_W{1'b0}};
        clk_out_s = !clk_out_r;
        tick_s    = !clk_out_r;
      end else begin
        cnt_s     = cnt_r + CNT_W'(1);
      end
      if (bnd_s && pend_valid_r) begin
        cur_half_s   = pend_r;
        pend_valid_s = 1'b0;
      end else begin
        cur_half_s   = cur_half_r;
      end
      // Captured after the boundary check so a same-cycle transfer waits a full period.
      if (ok_s) begin
        pend_s       = cfg_half;
        pend_valid_s = 1'b1;
      end else begin
        pend_s       = pend_r;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_MHz) begin
    if (reset) begin
      cnt_r        <= {CNT_W{1'b0}};
      clk_out_r    <= 1'b0;
      tick_r       <= 1'b0;
      cur_half_r   <= CNT_W'(DEFAULT_HALF);
      pend_r       <= {CNT_W{1'b0}};
      pend_valid_r <= 1'b0;
      cfg_ready_r  <= 1'b1;
      cfg_err_r    <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      clk_out_r    <= clk_out_s;
      tick_r       <= tick_s;
      cur_half_r   <= cur_half_s;
      pend_r       <= pend_s;
      pend_valid_r <= pend_valid_s;
      cfg_ready_r  <= cfg_ready_s;
      cfg_err_r    <= cfg_err_s;
    end
  end

  assign cfg_ready = cfg_ready_r;
  assign cfg_err   = cfg_err_r;
  assign clk_out   = clk_out_r;
  assign tick      = tick_r;
  assign active    = counting_s;
  assign cur_half  = cur_half_r;

endmodule
